// File: rtl/snow64_vector_muldiv_issuer.sv
// Issues one vector mul/div command at a time, waits for the selected unit's
// result pulse (or a watchdog timeout) and holds the result until consumed.
module snow64_vector_muldiv_issuer #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned MAX_WAIT   = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_div,
    input  logic [1:0]            in_int_type_size,
    input  logic                  in_type_signedness,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,

    output logic                  mul_enable,
    output logic [1:0]            mul_int_type_size,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    input  logic                  mul_valid,
    input  logic [DATA_WIDTH-1:0] mul_data,

    output logic                  div_enable,
    output logic [1:0]            div_int_type_size,
    output logic                  div_type_signedness,
    output logic [DATA_WIDTH-1:0] div_a,
    output logic [DATA_WIDTH-1:0] div_b,
    input  logic                  div_valid,
    input  logic [DATA_WIDTH-1:0] div_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_is_div,
    output logic                  out_timeout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t                state_q, state_d;
    logic                  is_div_q, is_div_d;
    logic [1:0]            size_q, size_d;
    logic                  sign_q, sign_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  timeout_q, timeout_d;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;

    // Only the unit that was issued to can complete the operation.
    assign resp_valid = is_div_q ? div_valid : mul_valid;
    assign resp_data  = is_div_q ? div_data  : mul_data;

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        size_d    = size_q;
        sign_d    = sign_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    is_div_d = in_is_div;
                    size_d   = in_int_type_size;
                    sign_d   = in_type_signedness;
                    a_d      = in_a;
                    b_d      = in_b;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the last allowed cycle beats the watchdog.
                if (resp_valid) begin
                    res_d     = resp_data;
                    timeout_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    res_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            is_div_q  <= 1'b0;
            size_q    <= '0;
            sign_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            timeout_q <= timeout_d;
        end
    end

    assign in_ready            = (state_q == ST_IDLE);
    assign busy                = (state_q != ST_IDLE);
    assign out_valid           = (state_q == ST_DONE);
    assign mul_enable          = (state_q == ST_ISSUE) && !is_div_q;
    assign div_enable          = (state_q == ST_ISSUE) && is_div_q;
    assign mul_int_type_size   = size_q;
    assign mul_a               = a_q;
    assign mul_b               = b_q;
    assign div_int_type_size   = size_q;
    assign div_type_signedness = sign_q;
    assign div_a               = a_q;
    assign div_b               = b_q;
    assign out_data            = res_q;
    assign out_is_div          = is_div_q;
    assign out_timeout         = timeout_q;

endmodule

// File: tb/tb_snow64_vector_muldiv_issuer.sv
// Directed bench for snow64_vector_muldiv_issuer: a vector table for normal
// operations plus hand sequences for backpressure, watchdog, cross-talk and reset.
module tb_snow64_vector_muldiv_issuer;

    localparam int unsigned DW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid_a = 1'b0;
    logic          in_valid_w = 1'b0;
    logic          in_is_div = 1'b0;
    logic [1:0]    in_int_type_size = '0;
    logic          in_type_signedness = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          mul_valid = 1'b0;
    logic [DW-1:0] mul_data = '0;
    logic          div_valid = 1'b0;
    logic [DW-1:0] div_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, mul_enable, div_enable, div_type_signedness;
    logic [1:0]    mul_int_type_size, div_int_type_size;
    logic [DW-1:0] mul_a, mul_b, div_a, div_b, out_data;
    logic          out_valid, out_is_div, out_timeout, busy;

    logic          w_in_ready, w_mul_enable, w_div_enable, w_div_type_signedness;
    logic [1:0]    w_mul_int_type_size, w_div_int_type_size;
    logic [DW-1:0] w_mul_a, w_mul_b, w_div_a, w_div_b, w_out_data;
    logic          w_out_valid, w_out_is_div, w_out_timeout, w_busy;

    always #5 clk = ~clk;

    snow64_vector_muldiv_issuer #(.DATA_WIDTH(DW), .MAX_WAIT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready), .in_is_div(in_is_div),
        .in_int_type_size(in_int_type_size), .in_type_signedness(in_type_signedness),
        .in_a(in_a), .in_b(in_b),
        .mul_enable(mul_enable), .mul_int_type_size(mul_int_type_size),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_data(mul_data),
        .div_enable(div_enable), .div_int_type_size(div_int_type_size),
        .div_type_signedness(div_type_signedness), .div_a(div_a), .div_b(div_b),
        .div_valid(div_valid), .div_data(div_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_div(out_is_div), .out_timeout(out_timeout), .busy(busy)
    );

    snow64_vector_muldiv_issuer #(.DATA_WIDTH(DW), .MAX_WAIT(8)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_w), .in_ready(w_in_ready), .in_is_div(in_is_div),
        .in_int_type_size(in_int_type_size), .in_type_signedness(in_type_signedness),
        .in_a(in_a), .in_b(in_b),
        .mul_enable(w_mul_enable), .mul_int_type_size(w_mul_int_type_size),
        .mul_a(w_mul_a), .mul_b(w_mul_b), .mul_valid(mul_valid), .mul_data(mul_data),
        .div_enable(w_div_enable), .div_int_type_size(w_div_int_type_size),
        .div_type_signedness(w_div_type_signedness), .div_a(w_div_a), .div_b(w_div_b),
        .div_valid(div_valid), .div_data(div_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .out_is_div(w_out_is_div), .out_timeout(w_out_timeout), .busy(w_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic is_div, input logic [1:0] size, input logic sign,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_is_div          = is_div;
        in_int_type_size   = size;
        in_type_signedness = sign;
        in_a               = a;
        in_b               = b;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic          is_div;
        logic [1:0]    size;
        logic          sign;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int unsigned   lat;
        logic [DW-1:0] resp;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic          ok;
        logic [DW-1:0] held;

        vecs[0] = '{1'b0, 2'd0, 1'b0, {32{8'h03}}, {32{8'h05}}, 4, {32{8'h0F}}, {32{8'h0F}}};
        vecs[1] = '{1'b1, 2'd2, 1'b1, {8{32'hFFFF_FF9C}}, {8{32'd7}}, 40,
                    {8{32'hFFFF_FFF2}}, {8{32'hFFFF_FFF2}}};
        vecs[2] = '{1'b0, 2'd3, 1'b0, {4{64'h0123_4567_89AB_CDEF}}, {4{64'h2}}, 1,
                    {4{64'h0246_8ACF_1357_9BDE}}, {4{64'h0246_8ACF_1357_9BDE}}};
        vecs[3] = '{1'b1, 2'd1, 1'b0, {16{16'h0084}}, {16{16'h0002}}, 8,
                    {16{16'h0042}}, {16{16'h0042}}};

        // Reset state
        #2;
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_enables", DW'({mul_enable, div_enable}), '0);
        chk("rst_cmd_a", mul_a, '0);
        chk("rst_out_data", out_data, '0);
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            set_req(vecs[i].is_div, vecs[i].size, vecs[i].sign, vecs[i].a, vecs[i].b);
            in_valid_a = 1'b1;
            tick();
            in_valid_a = 1'b0;
            set_req(1'b0, 2'd0, 1'b0, '1, '1);
            chk($sformatf("v%0d_mul_en", i), DW'(mul_enable), DW'(!vecs[i].is_div));
            chk($sformatf("v%0d_div_en", i), DW'(div_enable), DW'(vecs[i].is_div));
            chk($sformatf("v%0d_in_ready", i), DW'(in_ready), '0);
            chk($sformatf("v%0d_cmd", i),
                {mul_a[DW-1:8], mul_int_type_size, div_int_type_size, div_type_signedness},
                {vecs[i].a[DW-1:8], vecs[i].size, vecs[i].size, vecs[i].sign});
            chk($sformatf("v%0d_cmd_b", i), div_b, vecs[i].b);
            ok = 1'b1;
            for (int unsigned c = 1; c < vecs[i].lat; c++) begin
                tick();
                ok &= !out_valid && !mul_enable && !div_enable && busy
                      && div_type_signedness == vecs[i].sign && div_a == vecs[i].a
                      && mul_b == vecs[i].b;
            end
            tick();
            if (vecs[i].is_div) begin
                div_valid = 1'b1;
                div_data  = vecs[i].resp;
            end else begin
                mul_valid = 1'b1;
                mul_data  = vecs[i].resp;
            end
            tick();
            div_valid = 1'b0;
            mul_valid = 1'b0;
            chk($sformatf("v%0d_wait_stable", i), DW'(ok), DW'(1));
            chk($sformatf("v%0d_out_valid", i), DW'(out_valid), DW'(1));
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("v%0d_flags", i), DW'({out_is_div, out_timeout}),
                DW'({vecs[i].is_div, 1'b0}));
            release_result();
            chk($sformatf("v%0d_back_idle", i), DW'({in_ready, out_valid}), DW'(2'b10));
        end

        // Backpressure: result held for 10 cycles with out_ready low
        set_req(1'b0, 2'd1, 1'b0, {16{16'h0011}}, {16{16'h0003}});
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        tick();
        mul_valid = 1'b1;
        mul_data  = {16{16'h0033}};
        tick();
        mul_valid = 1'b0;
        mul_data  = '0;
        held = out_data;
        chk("bp_data", held, {16{16'h0033}});
        ok = 1'b1;
        for (int unsigned c = 0; c < 10; c++) begin
            tick();
            ok &= out_valid && !in_ready && out_data == held;
        end
        chk("bp_hold", DW'(ok), DW'(1));
        out_ready = 1'b1;
        chk("bp_no_bypass", DW'(in_ready), '0);
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_next", DW'({in_ready, out_valid}), DW'(2'b10));

        // Watchdog (MAX_WAIT=8): valid on final WAIT cycle still wins
        set_req(1'b1, 2'd2, 1'b1, {8{32'd50}}, {8{32'd5}});
        in_valid_w = 1'b1;
        tick();
        in_valid_w = 1'b0;
        chk("wd1_div_en", DW'({w_div_enable, w_mul_enable}), DW'(2'b10));
        ok = 1'b1;
        for (int unsigned c = 1; c < 8; c++) begin
            tick();
            ok &= !w_out_valid;
        end
        tick();
        div_valid = 1'b1;
        div_data  = {8{32'd10}};
        tick();
        div_valid = 1'b0;
        chk("wd1_quiet", DW'(ok), DW'(1));
        chk("wd1_out_valid", DW'(w_out_valid), DW'(1));
        chk("wd1_timeout", DW'(w_out_timeout), '0);
        chk("wd1_data", w_out_data, {8{32'd10}});
        release_result();

        // Watchdog: no response, timeout result 9 cycles after ISSUE
        in_valid_w = 1'b1;
        tick();
        in_valid_w = 1'b0;
        ok = 1'b1;
        for (int unsigned c = 1; c <= 8; c++) begin
            tick();
            ok &= !w_out_valid;
        end
        tick();
        chk("wd2_quiet", DW'(ok), DW'(1));
        chk("wd2_out_valid", DW'(w_out_valid), DW'(1));
        chk("wd2_timeout", DW'({w_out_timeout, w_out_is_div}), DW'(2'b11));
        chk("wd2_data", w_out_data, '0);
        release_result();
        chk("wd2_idle", DW'(w_in_ready), DW'(1));

        // Cross-talk: div_valid during a mul op is ignored
        set_req(1'b0, 2'd0, 1'b0, {32{8'h02}}, {32{8'h04}});
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        tick();
        div_valid = 1'b1;
        div_data  = {16{16'hDEAD}};
        tick();
        div_valid = 1'b0;
        chk("xt_div_ignored", DW'({out_valid, busy}), DW'(2'b01));
        tick();
        mul_valid = 1'b1;
        mul_data  = {32{8'h08}};
        tick();
        mul_valid = 1'b0;
        chk("xt_mul_data", out_data, {32{8'h08}});
        mul_valid = 1'b1;
        mul_data  = {32{8'h77}};
        tick();
        mul_valid = 1'b0;
        chk("xt_done_ignore", out_data, {32{8'h08}});
        chk("xt_done_state", DW'(out_valid), DW'(1));
        release_result();
        mul_valid = 1'b1;
        tick();
        mul_valid = 1'b0;
        tick();
        chk("xt_idle_ignore", DW'({in_ready, out_valid, busy}), DW'(3'b100));
        chk("xt_idle_data", out_data, {32{8'h08}});

        // Reset three cycles into WAIT
        set_req(1'b0, 2'd3, 1'b0, {4{64'h5}}, {4{64'h6}});
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rw_state", DW'({in_ready, out_valid, busy, mul_enable}), DW'(4'b1000));
        chk("rw_cmd", mul_a, '0);
        chk("rw_res", out_data, '0);
        tick();
        rst_n = 1'b1;
        mul_valid = 1'b1;
        mul_data  = {4{64'h1E}};
        tick();
        mul_valid = 1'b0;
        tick();
        chk("rw_late_valid", DW'({in_ready, out_valid}), DW'(2'b10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
